// File: rtl/fetch_types.sv
// fetch_types: fetch FSM state encoding and PC helpers.
package fetch_types;
    typedef enum logic [1:0] {FETCH, HOLD, DISCARD} fetch_state_t;

    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction
endpackage

// File: rtl/pcmux.sv
// pcmux: PC source selection shared between control and fetch.
package pcmux;
    typedef enum logic [1:0] {
        pc_plus4 = 2'b00,
        alu_out  = 2'b01,
        alu_mod2 = 2'b10
    } pcmux_sel_t;
endpackage

// File: rtl/fetch_hold_reg.sv
// fetch_hold_reg: parks a fetched word and its PC while IF/ID is stalled.
module fetch_hold_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        capture,
    input  logic        clear,
    input  logic [31:0] inst_d,
    input  logic [31:0] pc_d,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        valid
);
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            inst  <= 32'd0;
            pc    <= 32'd0;
            valid <= 1'b0;
        end else if (capture) begin
            inst  <= inst_d;
            pc    <= pc_d;
            valid <= 1'b1;
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch with stall hold and redirect of in-flight reads.
module fetch_unit
    import fetch_types::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0060
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_buffers,
    input  pcmux::pcmux_sel_t  pc_mux_sel,
    input  logic [31:0]        alu_out,
    output logic [31:0]        inst_mem_address,
    output logic               inst_mem_read,
    input  logic [31:0]        inst_mem_rdata,
    input  logic               inst_mem_resp,
    output logic [31:0]        if_pc,
    output logic [31:0]        if_inst,
    output logic               if_valid
);
    fetch_state_t state, state_n;
    logic [31:0]  req_addr, req_n, next_pc, npc_n, target;
    logic [31:0]  hold_inst, hold_pc;
    logic         hold_valid, capture, drop, redirect;

    assign redirect = pc_mux_sel != pcmux::pc_plus4;
    assign target   = pc_mux_sel == pcmux::alu_mod2 ? alu_out & 32'hFFFF_FFFE : alu_out;

    fetch_hold_reg u_hold (
        .clk    (clk),
        .rst    (rst),
        .capture(capture),
        .clear  (drop),
        .inst_d (inst_mem_rdata),
        .pc_d   (req_addr),
        .inst   (hold_inst),
        .pc     (hold_pc),
        .valid  (hold_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            req_addr <= PC_RESET;
            next_pc  <= PC_RESET;
        end else begin
            state    <= state_n;
            req_addr <= req_n;
            next_pc  <= npc_n;
        end
    end

    // An issued read is never abandoned: a redirect before its response parks in DISCARD.
    always_comb begin
        state_n = state;
        req_n   = req_addr;
        npc_n   = next_pc;
        capture = 1'b0;
        drop    = 1'b0;
        case (state)
            FETCH: begin
                if (inst_mem_resp) begin
                    if (redirect) req_n = target;
                    else if (load_buffers) req_n = pc_inc(req_addr);
                    else begin
                        capture = 1'b1;
                        state_n = HOLD;
                    end
                end else if (redirect) begin
                    npc_n   = target;
                    state_n = DISCARD;
                end
            end
            HOLD: begin
                if (redirect || load_buffers) begin
                    req_n   = redirect ? target : pc_inc(hold_pc);
                    drop    = 1'b1;
                    state_n = FETCH;
                end
            end
            DISCARD: begin
                if (redirect) npc_n = target;
                if (inst_mem_resp) begin
                    req_n   = redirect ? target : next_pc;
                    state_n = FETCH;
                end
            end
            default: state_n = FETCH;
        endcase
    end

    assign inst_mem_address = req_addr;
    assign inst_mem_read    = ~rst & (state != HOLD);
    assign if_valid = ~rst & ~redirect & (state == FETCH ? inst_mem_resp : state == HOLD & hold_valid);
    assign if_inst  = rst ? 32'd0 : state == HOLD ? hold_inst : inst_mem_rdata;
    assign if_pc    = rst ? 32'd0 : state == HOLD ? hold_pc : req_addr;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized run against a program-order PC model.
module tb_fetch_unit;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               load_buffers = 1'b0;
    pcmux::pcmux_sel_t  pc_mux_sel = pcmux::pc_plus4;
    logic [31:0]        alu_res = 32'd0;
    logic [31:0]        inst_mem_address;
    logic               inst_mem_read;
    logic [31:0]        inst_mem_rdata = 32'd0;
    logic               inst_mem_resp = 1'b0;
    logic [31:0]        if_pc, if_inst;
    logic               if_valid;
    int                 checks = 0;
    int                 errors = 0;

    fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .load_buffers    (load_buffers),
        .pc_mux_sel      (pc_mux_sel),
        .alu_out         (alu_res),
        .inst_mem_address(inst_mem_address),
        .inst_mem_read   (inst_mem_read),
        .inst_mem_rdata  (inst_mem_rdata),
        .inst_mem_resp   (inst_mem_resp),
        .if_pc           (if_pc),
        .if_inst         (if_inst),
        .if_valid        (if_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic drive(input logic lb, input pcmux::pcmux_sel_t sel, input logic [31:0] ao, input logic resp);
        @(negedge clk);
        load_buffers   = lb;
        pc_mux_sel     = sel;
        alu_res        = ao;
        inst_mem_resp  = resp;
        inst_mem_rdata = word(inst_mem_address);
        #1;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1;
        load_buffers = 1'b0;
        pc_mux_sel = pcmux::pc_plus4;
        alu_res = 32'd0;
        inst_mem_resp = 1'b0;
        inst_mem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1;
        inst_mem_rdata = 32'hDEAD_BEEF;
        inst_mem_resp = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (inst_mem_read !== 1'b0) begin errors++; $display("FAIL reset_read: got %0b want 0", inst_mem_read); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", if_valid); end
        checks++; if (if_pc !== 32'd0 || if_inst !== 32'd0) begin errors++; $display("FAIL reset_outs: pc %h inst %h want 0", if_pc, if_inst); end
        checks++; if (inst_mem_address !== 32'h60) begin errors++; $display("FAIL reset_addr: got %h want 00000060", inst_mem_address); end
        rst = 1'b0;
        #1;
        checks++; if (inst_mem_read !== 1'b1 || inst_mem_address !== 32'h60) begin errors++; $display("FAIL first_req: read %0b addr %h want 1 00000060", inst_mem_read, inst_mem_address); end
        drive(1'b1, pcmux::pc_plus4, 32'd0, 1'b1);
        drive(1'b1, pcmux::pc_plus4, 32'd0, 1'b0);
        checks++; if (inst_mem_address !== 32'h64) begin errors++; $display("FAIL pre_mid_reset: addr %h want 00000064", inst_mem_address); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (inst_mem_read !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL mid_reset: read %0b valid %0b want 0 0", inst_mem_read, if_valid); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (inst_mem_read !== 1'b1 || inst_mem_address !== 32'h60) begin errors++; $display("FAIL after_mid_reset: read %0b addr %h want 1 00000060", inst_mem_read, inst_mem_address); end
    endtask

    task automatic test_back_to_back;
        do_reset;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, pcmux::pc_plus4, 32'd0, 1'b1);
            checks++;
            if (inst_mem_address !== 32'h60 + 4 * i || if_valid !== 1'b1 || if_pc !== 32'h60 + 4 * i || if_inst !== word(32'h60 + 4 * i)) begin
                errors++;
                $display("FAIL stream%0d: addr %h valid %0b pc %h inst %h want addr/pc %h valid 1", i, inst_mem_address, if_valid, if_pc, if_inst, 32'h60 + 4 * i);
            end
        end
    endtask

    task automatic test_hold;
        do_reset;
        drive(1'b1, pcmux::pc_plus4, 32'd0, 1'b1);
        drive(1'b0, pcmux::pc_plus4, 32'd0, 1'b1);
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h64) begin errors++; $display("FAIL hold_capture: valid %0b pc %h want 1 00000064", if_valid, if_pc); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, pcmux::pc_plus4, 32'd0, 1'b0);
            checks++;
            if (if_valid !== 1'b1 || if_pc !== 32'h64 || if_inst !== word(32'h64) || inst_mem_read !== 1'b0) begin
                errors++;
                $display("FAIL hold%0d: valid %0b pc %h inst %h read %0b want 1 00000064 %h 0", i, if_valid, if_pc, if_inst, inst_mem_read, word(32'h64));
            end
        end
        drive(1'b1, pcmux::pc_plus4, 32'd0, 1'b0);
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h64) begin errors++; $display("FAIL hold_release: valid %0b pc %h want 1 00000064", if_valid, if_pc); end
        drive(1'b1, pcmux::pc_plus4, 32'd0, 1'b0);
        checks++; if (inst_mem_read !== 1'b1 || inst_mem_address !== 32'h68) begin errors++; $display("FAIL hold_next: read %0b addr %h want 1 00000068", inst_mem_read, inst_mem_address); end
    endtask

    task automatic test_redirect_pending;
        do_reset;
        repeat (4) drive(1'b1, pcmux::pc_plus4, 32'd0, 1'b1);
        drive(1'b1, pcmux::alu_out, 32'h200, 1'b0);
        checks++; if (inst_mem_address !== 32'h70 || if_valid !== 1'b0) begin errors++; $display("FAIL redir_issue: addr %h valid %0b want 00000070 0", inst_mem_address, if_valid); end
        repeat (2) begin
            drive(1'b1, pcmux::pc_plus4, 32'd0, 1'b0);
            checks++; if (inst_mem_address !== 32'h70 || inst_mem_read !== 1'b1 || if_valid !== 1'b0) begin errors++; $display("FAIL redir_wait: addr %h read %0b valid %0b want 00000070 1 0", inst_mem_address, inst_mem_read, if_valid); end
        end
        drive(1'b1, pcmux::pc_plus4, 32'd0, 1'b1);
        checks++; if (inst_mem_address !== 32'h70 || if_valid !== 1'b0) begin errors++; $display("FAIL redir_resp: addr %h valid %0b want 00000070 0", inst_mem_address, if_valid); end
        drive(1'b1, pcmux::pc_plus4, 32'd0, 1'b0);
        checks++; if (inst_mem_address !== 32'h200 || inst_mem_read !== 1'b1) begin errors++; $display("FAIL redir_next: addr %h read %0b want 00000200 1", inst_mem_address, inst_mem_read); end
    endtask

    task automatic test_double_redirect;
        do_reset;
        drive(1'b1, pcmux::alu_out, 32'h300, 1'b0);
        drive(1'b1, pcmux::alu_out, 32'h400, 1'b0);
        drive(1'b1, pcmux::pc_plus4, 32'd0, 1'b1);
        checks++; if (if_valid !== 1'b0 || inst_mem_address !== 32'h60) begin errors++; $display("FAIL dbl_resp: valid %0b addr %h want 0 00000060", if_valid, inst_mem_address); end
        drive(1'b1, pcmux::pc_plus4, 32'd0, 1'b0);
        checks++; if (inst_mem_address !== 32'h400) begin errors++; $display("FAIL dbl_next: addr %h want 00000400", inst_mem_address); end
    endtask

    task automatic test_hold_redirect;
        do_reset;
        drive(1'b0, pcmux::pc_plus4, 32'd0, 1'b1);
        drive(1'b1, pcmux::alu_mod2, 32'h1235, 1'b0);
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL hold_redir_valid: got %0b want 0", if_valid); end
        drive(1'b1, pcmux::pc_plus4, 32'd0, 1'b0);
        checks++; if (inst_mem_address !== 32'h1234 || inst_mem_read !== 1'b1) begin errors++; $display("FAIL hold_redir_next: addr %h read %0b want 00001234 1", inst_mem_address, inst_mem_read); end
    endtask

    task automatic test_wrap;
        do_reset;
        drive(1'b1, pcmux::alu_out, 32'hFFFF_FFFC, 1'b1);
        drive(1'b1, pcmux::pc_plus4, 32'd0, 1'b1);
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_present: valid %0b pc %h want 1 fffffffc", if_valid, if_pc); end
        drive(1'b1, pcmux::pc_plus4, 32'd0, 1'b0);
        checks++; if (inst_mem_address !== 32'd0) begin errors++; $display("FAIL wrap_next: addr %h want 00000000", inst_mem_address); end
    endtask

    // Model: the next accepted instruction is always exp_pc; a redirect squashes and re-targets.
    task automatic test_random;
        int lat, accepted;
        logic [31:0] exp_pc, prev_addr, ao, tgt;
        logic prev_pend, lb, resp, redir;
        pcmux::pcmux_sel_t sel;
        do_reset;
        exp_pc = 32'h60;
        lat = $urandom_range(0, 2);
        prev_pend = 1'b0;
        prev_addr = 32'd0;
        accepted = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            lb = $urandom_range(0, 3) != 0;
            case ($urandom_range(0, 15))
                0: sel = pcmux::alu_out;
                1: sel = pcmux::alu_mod2;
                default: sel = pcmux::pc_plus4;
            endcase
            ao = $urandom_range(0, 3) == 0 ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            resp = 1'b0;
            if (inst_mem_read) begin
                if (lat == 0) begin
                    resp = 1'b1;
                    lat = $urandom_range(0, 2);
                end else lat--;
            end
            if (prev_pend) begin
                checks++;
                if (inst_mem_read !== 1'b1 || inst_mem_address !== prev_addr) begin
                    errors++;
                    $display("FAIL rnd_stable @%0d: read %0b addr %h want 1 %h", i, inst_mem_read, inst_mem_address, prev_addr);
                end
            end
            load_buffers = lb;
            pc_mux_sel = sel;
            alu_res = ao;
            inst_mem_resp = resp;
            inst_mem_rdata = word(inst_mem_address);
            #1;
            redir = sel != pcmux::pc_plus4;
            tgt = sel == pcmux::alu_mod2 ? {ao[31:1], 1'b0} : ao;
            if (redir) begin
                checks++;
                if (if_valid !== 1'b0) begin errors++; $display("FAIL rnd_squash @%0d: valid %0b want 0", i, if_valid); end
                exp_pc = tgt;
            end else if (if_valid === 1'b1) begin
                checks++;
                if (if_pc !== exp_pc || if_inst !== word(exp_pc)) begin
                    errors++;
                    $display("FAIL rnd_order @%0d: pc %h inst %h want %h %h", i, if_pc, if_inst, exp_pc, word(exp_pc));
                end
                if (lb) begin
                    exp_pc = exp_pc + 32'd4;
                    accepted++;
                end
            end else if (if_valid !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL rnd_valid_x @%0d: got %b want 0/1", i, if_valid);
            end
            prev_pend = inst_mem_read && !resp;
            prev_addr = inst_mem_address;
        end
        checks++;
        if (accepted < 300) begin errors++; $display("FAIL rnd_progress: accepted %0d want >= 300", accepted); end
    endtask

    initial begin
        test_reset;
        test_back_to_back;
        test_hold;
        test_redirect_pending;
        test_double_redirect;
        test_hold_redirect;
        test_wrap;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
